// File: rtl/netlist_sig_bist.sv
// LFSR pattern source and MISR response compactor for combinational netlist BIST.
// Optional golden-signature compare is enabled by defining SIG_GOLDEN_EN.
module netlist_sig_bist #(
    parameter int unsigned      IN_W        = 14,
    parameter int unsigned      OUT_W       = 8,
    parameter int unsigned      SIG_W       = 16,
    parameter logic [IN_W-1:0]  LFSR_TAPS   = 14'h002B,
    parameter logic [SIG_W-1:0] MISR_TAPS   = 16'h100B,
    parameter int unsigned      PATTERN_CNT = 256,
    parameter int unsigned      RESP_LAT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [IN_W-1:0]  seed,
    input  logic             start,
    output logic [IN_W-1:0]  pat_out,
    output logic             pat_valid,
    input  logic [OUT_W-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
`ifdef SIG_GOLDEN_EN
    ,
    input  logic [SIG_W-1:0] golden,
    output logic             pass
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    localparam logic [15:0] LastCnt   = 16'(PATTERN_CNT - 1);
    localparam logic [1:0]  LastFlush = 2'((RESP_LAT == 0) ? 0 : RESP_LAT - 1);

    state_e            state_q, state_d;
    logic [IN_W-1:0]   lfsr_q, lfsr_d;
    logic [IN_W-1:0]   pat_out_q, pat_out_d;
    logic              pat_valid_q, pat_valid_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        flush_q, flush_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [IN_W-1:0]   seed_fixed;
    logic              cap_valid;

`ifdef SIG_GOLDEN_EN
    logic [SIG_W-1:0]  golden_q, golden_d;
    logic              pass_q, pass_d;
`endif

    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] v);
        return {v[IN_W-2:0], 1'b0} ^ (v[IN_W-1] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                    input logic [OUT_W-1:0] r);
        return ({s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_TAPS : '0)) ^ SIG_W'(r);
    endfunction

    // pat_valid delayed to line up with the netlist response
    generate
        if (RESP_LAT == 0) begin : g_no_lat
            assign cap_valid = pat_valid_q;
        end else begin : g_lat
            logic [RESP_LAT-1:0] dly_q, dly_d;

            always_comb begin
                dly_d    = dly_q << 1;
                dly_d[0] = pat_valid_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign cap_valid = dly_q[RESP_LAT-1];
        end
    endgenerate

    // An all-zero seed would lock the LFSR up
    assign seed_fixed = (seed == '0) ? IN_W'(1) : seed;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        pat_out_d   = pat_out_q;
        pat_valid_d = pat_valid_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        sig_d       = sig_q;
`ifdef SIG_GOLDEN_EN
        golden_d    = golden_q;
        pass_d      = pass_q;
`endif

        if (cap_valid) begin
            sig_d = misr_step(sig_q, resp_in);
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    pat_out_d   = seed_load ? seed_fixed : lfsr_q;
                    lfsr_d      = lfsr_step(pat_out_d);
                    pat_valid_d = 1'b1;
                    cnt_d       = '0;
                    sig_d       = '0;
                    state_d     = StRun;
`ifdef SIG_GOLDEN_EN
                    golden_d    = golden;
                    pass_d      = 1'b0;
`endif
                end else if (seed_load) begin
                    lfsr_d = seed_fixed;
                end
            end
            StRun: begin
                if (cnt_q == LastCnt) begin
                    pat_valid_d = 1'b0;
                    flush_d     = '0;
                    state_d     = (RESP_LAT == 0) ? StDone : StFlush;
                end else begin
                    pat_out_d = lfsr_q;
                    lfsr_d    = lfsr_step(lfsr_q);
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            StFlush: begin
                if (flush_q == LastFlush) begin
                    state_d = StDone;
                end else begin
                    flush_d = flush_q + 2'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef SIG_GOLDEN_EN
        // Compare against the final signature so pass is valid alongside done
        if (state_d == StDone && state_q != StDone) begin
            pass_d = (sig_d == golden_q);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lfsr_q      <= IN_W'(1);
            pat_out_q   <= '0;
            pat_valid_q <= 1'b0;
            cnt_q       <= '0;
            flush_q     <= '0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pat_out_q   <= pat_out_d;
            pat_valid_q <= pat_valid_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            sig_q       <= sig_d;
        end
    end

`ifdef SIG_GOLDEN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            golden_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            golden_q <= golden_d;
            pass_q   <= pass_d;
        end
    end

    assign pass = pass_q;
`endif

    assign pat_out   = pat_out_q;
    assign pat_valid = pat_valid_q;
    assign busy      = (state_q == StRun) || (state_q == StFlush);
    assign done      = (state_q == StDone);
    assign signature = sig_q;

endmodule
